// File: rtl/pcap_dma_ctrl.sv
// ---------------------------------------------------------------------------
// pcap_dma_ctrl
//
// Moves position-capture data from the capture data FIFO into host memory
// blocks. Keeps a current/pending host block address pair, issues full bursts
// of BURST_LEN words (or partial bursts when flushing), counts the bytes
// written into each block and raises a single-cycle IRQ when a block closes
// (full, capture done, timeout, address starvation) or when a burst is aborted.
//
// Optional feature: define PCAP_DMA_STATS_EN to add blocks_o (blocks closed)
// and starved_o (cycles spent waiting for an address). Both wrap at 2^32.
//
// Ports:
//   clk_i, reset_i      clock, synchronous active-high reset
//   dma_reset_i         abort: back to IDLE, address pair cleared
//   dma_start_i         promote pending address to current and start
//   dma_addr_i/_wstb_i  host block base address and its load strobe
//   block_size_i        block size in bytes (multiple of 4*BURST_LEN)
//   timeout_i           flush timeout in clk_i cycles, 0 disables
//   pcap_done_i         capture finished: flush and close the block
//   fifo_count_i        words available in the data FIFO
//   dma_req_o/_addr_o/_len_o/dma_ack_i   burst request handshake
//   irq_o, irq_flags_o, irq_words_o       interrupt pulse and its report
//     flags: b0 block full, b1 capture done, b2 timeout, b3 starved, b4 abort
// ---------------------------------------------------------------------------
module pcap_dma_ctrl #(
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned CNT_W     = 11
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             dma_reset_i,
  input  logic             dma_start_i,
  input  logic [31:0]      dma_addr_i,
  input  logic             dma_addr_wstb_i,
  input  logic [31:0]      block_size_i,
  input  logic [31:0]      timeout_i,
  input  logic             pcap_done_i,
  input  logic [CNT_W-1:0] fifo_count_i,
  output logic             dma_req_o,
  output logic [31:0]      dma_addr_o,
  output logic [8:0]       dma_len_o,
  input  logic             dma_ack_i,
  output logic             irq_o,
  output logic [7:0]       irq_flags_o,
  output logic [15:0]      irq_words_o
`ifdef PCAP_DMA_STATS_EN
  ,
  output logic [31:0]      blocks_o,
  output logic [31:0]      starved_o
`endif
);

  localparam logic [8:0]       BURST_LEN_L = 9'(BURST_LEN);
  localparam logic [CNT_W-1:0] BURST_CNT_L = CNT_W'(BURST_LEN);

  localparam logic [7:0] FLAG_FULL   = 8'h01;
  localparam logic [7:0] FLAG_DONE   = 8'h02;
  localparam logic [7:0] FLAG_TMO    = 8'h04;
  localparam logic [7:0] FLAG_STARVE = 8'h08;
  localparam logic [7:0] FLAG_ABORT  = 8'h10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_CLOSE    = 3'd3,
    ST_STARVED  = 3'd4
  } state_t;

  // Words written so far, saturated to the 16-bit report field.
  function automatic logic [15:0] sat_words(input logic [31:0] off);
    if (off > 32'h0003_FFFF) begin
      return 16'hFFFF;
    end else begin
      return off[17:2];
    end
  endfunction

  state_t      state_q, state_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] cur_addr_q, cur_addr_d;
  logic [31:0] offset_q, offset_d;
  logic        done_q, done_d;
  logic        tmo_flag_q, tmo_flag_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]  flags_acc_q, flags_acc_d;
  logic        partial_q, partial_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [8:0]  len_q, len_d;
  logic        irq_q, irq_d;
  logic [7:0]  irq_flags_q, irq_flags_d;
  logic [15:0] irq_words_q, irq_words_d;

  logic        activity_s;
  logic        tmo_hit_s;
  logic        flush_s;
  logic [31:0] off_next_s;

  assign activity_s = (offset_q != 32'd0) || (fifo_count_i != '0);
  assign tmo_hit_s  = (state_q == ST_RUN) && activity_s && (timeout_i != 32'd0) &&
                      (tmo_cnt_q == (timeout_i - 32'd1));
  // A flush is due once capture is done or the timeout has fired.
  assign flush_s    = done_q || tmo_flag_q || tmo_hit_s;
  assign off_next_s = offset_q + {21'd0, len_q, 2'b00};

  // Next-state and output decode for the transfer sequencer.
  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    pend_vld_d  = pend_vld_q;
    cur_addr_d  = cur_addr_q;
    offset_d    = offset_q;
    done_d      = done_q;
    tmo_flag_d  = tmo_flag_q;
    tmo_cnt_d   = tmo_cnt_q;
    flags_acc_d = flags_acc_q;
    partial_d   = partial_q;
    req_d       = req_q;
    addr_d      = addr_q;
    len_d       = len_q;
    irq_d       = 1'b0;
    irq_flags_d = irq_flags_q;
    irq_words_d = irq_words_q;

    if (dma_reset_i) begin
      // Abort wins over everything; only an in-flight burst reports it.
      state_d     = ST_IDLE;
      pend_addr_d = 32'd0;
      pend_vld_d  = 1'b0;
      cur_addr_d  = 32'd0;
      offset_d    = 32'd0;
      done_d      = 1'b0;
      tmo_flag_d  = 1'b0;
      tmo_cnt_d   = 32'd0;
      flags_acc_d = 8'h00;
      partial_d   = 1'b0;
      req_d       = 1'b0;
      addr_d      = 32'd0;
      len_d       = 9'd0;
      irq_words_d = 16'h0000;
      if (state_q == ST_WAIT_ACK) begin
        irq_d       = 1'b1;
        irq_flags_d = FLAG_ABORT;
      end else begin
        irq_d       = 1'b0;
        irq_flags_d = 8'h00;
      end
    end else begin
      // Capture-done is remembered everywhere except IDLE.
      if (pcap_done_i && (state_q != ST_IDLE)) begin
        done_d = 1'b1;
      end else begin
        done_d = done_q;
      end

      if ((state_q == ST_RUN) && activity_s) begin
        tmo_cnt_d = tmo_cnt_q + 32'd1;
      end else begin
        tmo_cnt_d = tmo_cnt_q;
      end

      if (tmo_hit_s) begin
        tmo_flag_d  = 1'b1;
        flags_acc_d = flags_acc_q | FLAG_TMO;
      end else begin
        tmo_flag_d  = tmo_flag_q;
      end

      case (state_q)
        ST_IDLE: begin
          if (dma_start_i && pend_vld_q) begin
            cur_addr_d = pend_addr_q;
            pend_vld_d = 1'b0;
            offset_d   = 32'd0;
            state_d    = ST_RUN;
          end else begin
            state_d    = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (fifo_count_i >= BURST_CNT_L) begin
            req_d     = 1'b1;
            addr_d    = cur_addr_q + offset_q;
            len_d     = BURST_LEN_L;
            partial_d = 1'b0;
            state_d   = ST_WAIT_ACK;
          end else if (flush_s && (fifo_count_i != '0)) begin
            req_d     = 1'b1;
            addr_d    = cur_addr_q + offset_q;
            len_d     = 9'(fifo_count_i);
            partial_d = 1'b1;
            state_d   = ST_WAIT_ACK;
          end else if (flush_s) begin
            state_d   = ST_CLOSE;
          end else begin
            state_d   = ST_RUN;
          end
        end
        ST_WAIT_ACK: begin
          if (dma_ack_i) begin
            req_d    = 1'b0;
            offset_d = off_next_s;
            if (off_next_s == block_size_i) begin
              flags_acc_d = flags_acc_d | FLAG_FULL;
              state_d     = ST_CLOSE;
            end else if (flush_s && (partial_q || (fifo_count_i == '0))) begin
              // A partial burst took everything the FIFO held.
              state_d     = ST_CLOSE;
            end else begin
              state_d     = ST_RUN;
            end
          end else begin
            state_d  = ST_WAIT_ACK;
          end
        end
        ST_CLOSE: begin
          irq_d       = 1'b1;
          irq_words_d = sat_words(offset_q);
          tmo_cnt_d   = 32'd0;
          tmo_flag_d  = 1'b0;
          flags_acc_d = 8'h00;
          partial_d   = 1'b0;
          if (done_q || pcap_done_i) begin
            irq_flags_d = flags_acc_q | FLAG_DONE;
            done_d      = 1'b0;
            state_d     = ST_IDLE;
          end else if (pend_vld_q) begin
            irq_flags_d = flags_acc_q;
            cur_addr_d  = pend_addr_q;
            pend_vld_d  = 1'b0;
            offset_d    = 32'd0;
            state_d     = ST_RUN;
          end else begin
            irq_flags_d = flags_acc_q | FLAG_STARVE;
            offset_d    = 32'd0;
            state_d     = ST_STARVED;
          end
        end
        ST_STARVED: begin
          // A fresh address goes straight to current; no IRQ for this.
          if (dma_addr_wstb_i) begin
            cur_addr_d = dma_addr_i;
            offset_d   = 32'd0;
            state_d    = ST_RUN;
          end else if (pend_vld_q) begin
            cur_addr_d = pend_addr_q;
            pend_vld_d = 1'b0;
            offset_d   = 32'd0;
            state_d    = ST_RUN;
          end else begin
            state_d    = ST_STARVED;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      // Pending slot load comes last so a same-cycle promotion keeps the new write.
      if (dma_addr_wstb_i && (state_q != ST_STARVED)) begin
        pend_addr_d = dma_addr_i;
        pend_vld_d  = 1'b1;
      end else begin
        pend_addr_d = pend_addr_d;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      pend_addr_q <= 32'd0;
      pend_vld_q  <= 1'b0;
      cur_addr_q  <= 32'd0;
      offset_q    <= 32'd0;
      done_q      <= 1'b0;
      tmo_flag_q  <= 1'b0;
      tmo_cnt_q   <= 32'd0;
      flags_acc_q <= 8'h00;
      partial_q   <= 1'b0;
      req_q       <= 1'b0;
      addr_q      <= 32'd0;
      len_q       <= 9'd0;
      irq_q       <= 1'b0;
      irq_flags_q <= 8'h00;
      irq_words_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      pend_vld_q  <= pend_vld_d;
      cur_addr_q  <= cur_addr_d;
      offset_q    <= offset_d;
      done_q      <= done_d;
      tmo_flag_q  <= tmo_flag_d;
      tmo_cnt_q   <= tmo_cnt_d;
      flags_acc_q <= flags_acc_d;
      partial_q   <= partial_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      irq_q       <= irq_d;
      irq_flags_q <= irq_flags_d;
      irq_words_q <= irq_words_d;
    end
  end

  assign dma_req_o   = req_q;
  assign dma_addr_o  = addr_q;
  assign dma_len_o   = len_q;
  assign irq_o       = irq_q;
  assign irq_flags_o = irq_flags_q;
  assign irq_words_o = irq_words_q;

`ifdef PCAP_DMA_STATS_EN
  logic [31:0] blocks_q, blocks_d;
  logic [31:0] starved_q, starved_d;

  // Statistics next-state: blocks closed and cycles spent starved.
  always_comb begin
    blocks_d  = blocks_q;
    starved_d = starved_q;
    if (dma_reset_i) begin
      blocks_d  = 32'd0;
      starved_d = 32'd0;
    end else begin
      if (state_q == ST_CLOSE) begin
        blocks_d = blocks_q + 32'd1;
      end else begin
        blocks_d = blocks_q;
      end
      if (state_q == ST_STARVED) begin
        starved_d = starved_q + 32'd1;
      end else begin
        starved_d = starved_q;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      blocks_q  <= 32'd0;
      starved_q <= 32'd0;
    end else begin
      blocks_q  <= blocks_d;
      starved_q <= starved_d;
    end
  end

  assign blocks_o  = blocks_q;
  assign starved_o = starved_q;
`endif

endmodule

// File: tb/tb_pcap_dma_ctrl.sv
// Scoreboard bench for pcap_dma_ctrl: stimulus pushes expected bursts and
// IRQ reports into queues, a monitor pops and compares them as the DUT
// presents them.
module tb_pcap_dma_ctrl;

  localparam int BURST_LEN = 16;
  localparam int CNT_W     = 11;

  logic             clk = 1'b0;
  logic             reset_i = 1'b1;
  logic             dma_reset_i = 1'b0;
  logic             dma_start_i = 1'b0;
  logic [31:0]      dma_addr_i = 32'd0;
  logic             dma_addr_wstb_i = 1'b0;
  logic [31:0]      block_size_i = 32'd1024;
  logic [31:0]      timeout_i = 32'd0;
  logic             pcap_done_i = 1'b0;
  logic [CNT_W-1:0] fifo_count_i = '0;
  logic             dma_req_o;
  logic [31:0]      dma_addr_o;
  logic [8:0]       dma_len_o;
  logic             dma_ack_i = 1'b0;
  logic             irq_o;
  logic [7:0]       irq_flags_o;
  logic [15:0]      irq_words_o;
`ifdef PCAP_DMA_STATS_EN
  logic [31:0]      blocks_o;
  logic [31:0]      starved_o;
`endif

  pcap_dma_ctrl #(.BURST_LEN(BURST_LEN), .CNT_W(CNT_W)) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .dma_reset_i     (dma_reset_i),
    .dma_start_i     (dma_start_i),
    .dma_addr_i      (dma_addr_i),
    .dma_addr_wstb_i (dma_addr_wstb_i),
    .block_size_i    (block_size_i),
    .timeout_i       (timeout_i),
    .pcap_done_i     (pcap_done_i),
    .fifo_count_i    (fifo_count_i),
    .dma_req_o       (dma_req_o),
    .dma_addr_o      (dma_addr_o),
    .dma_len_o       (dma_len_o),
    .dma_ack_i       (dma_ack_i),
    .irq_o           (irq_o),
    .irq_flags_o     (irq_flags_o),
    .irq_words_o     (irq_words_o)
`ifdef PCAP_DMA_STATS_EN
    ,
    .blocks_o        (blocks_o),
    .starved_o       (starved_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [8:0]  len;
  } burst_t;

  typedef struct packed {
    logic [7:0]  flags;
    logic [15:0] words;
  } irq_t;

  burst_t exp_burst_q[$];
  irq_t   exp_irq_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic void push_burst(logic [31:0] addr, logic [8:0] len);
    burst_t b;
    b.addr = addr;
    b.len  = len;
    exp_burst_q.push_back(b);
  endfunction

  function automatic void push_irq(logic [7:0] flags, logic [15:0] words);
    irq_t q;
    q.flags = flags;
    q.words = words;
    exp_irq_q.push_back(q);
  endfunction

  // Monitor: compares each new burst request and each IRQ pulse with the scoreboard.
  initial begin : monitor
    logic        prev_req;
    logic [31:0] prev_addr;
    logic [8:0]  prev_len;
    burst_t      b;
    irq_t        q;
    prev_req  = 1'b0;
    prev_addr = 32'd0;
    prev_len  = 9'd0;
    forever begin
      @(negedge clk);
      if (dma_req_o && !prev_req) begin
        if (exp_burst_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_burst: got addr 0x%08h len %0d, none expected", dma_addr_o, dma_len_o);
        end else begin
          b = exp_burst_q.pop_front();
          check("burst_addr", dma_addr_o, b.addr);
          check("burst_len", 32'(dma_len_o), 32'(b.len));
        end
      end else if (dma_req_o && prev_req) begin
        check("burst_addr_stable", dma_addr_o, prev_addr);
        check("burst_len_stable", 32'(dma_len_o), 32'(prev_len));
      end
      if (irq_o) begin
        if (exp_irq_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_irq: got flags 0x%02h words %0d, none expected", irq_flags_o, irq_words_o);
        end else begin
          q = exp_irq_q.pop_front();
          check("irq_flags", 32'(irq_flags_o), 32'(q.flags));
          check("irq_words", 32'(irq_words_o), 32'(q.words));
        end
      end
      prev_req  = dma_req_o;
      prev_addr = dma_addr_o;
      prev_len  = dma_len_o;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_wstb(input logic [31:0] addr);
    dma_addr_i      = addr;
    dma_addr_wstb_i = 1'b1;
    tick(1);
    dma_addr_wstb_i = 1'b0;
  endtask

  task automatic pulse_start();
    dma_start_i = 1'b1;
    tick(1);
    dma_start_i = 1'b0;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 200; i++) begin
      if (dma_req_o) break;
      tick(1);
    end
    check("req_seen", 32'(dma_req_o), 32'd1);
  endtask

  task automatic ack_pulse();
    dma_ack_i = 1'b1;
    tick(1);
    dma_ack_i = 1'b0;
  endtask

  task automatic do_burst();
    wait_req();
    tick(2);
    ack_pulse();
  endtask

  // Stimulus: directed sequence of scenarios.
  initial begin : stim
    int cyc;

    // Reset state.
    tick(3);
    check("rst_req", 32'(dma_req_o), 32'd0);
    check("rst_addr", dma_addr_o, 32'd0);
    check("rst_len", 32'(dma_len_o), 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    check("rst_flags", 32'(irq_flags_o), 32'd0);
    check("rst_words", 32'(irq_words_o), 32'd0);
    reset_i = 1'b0;
    tick(2);

    // Full block of 16 bursts, then roll over to the next address.
    pulse_wstb(32'h1000_0000);
    pulse_start();
    pulse_wstb(32'h1000_0400);
    for (int i = 0; i < 16; i++) push_burst(32'h1000_0000 + 32'(64 * i), 9'd16);
    push_irq(8'h01, 16'd256);
    push_burst(32'h1000_0400, 9'd16);
    push_burst(32'h1000_0440, 9'd16);
    push_burst(32'h1000_0480, 9'd5);
    push_irq(8'h02, 16'd37);
    fifo_count_i = 11'd64;
    for (int i = 0; i < 17; i++) do_burst();

    // Capture done during the 18th burst with 5 words left.
    wait_req();
    fifo_count_i = 11'd5;
    pcap_done_i  = 1'b1;
    tick(1);
    pcap_done_i  = 1'b0;
    ack_pulse();
    do_burst();
    tick(4);
    fifo_count_i = 11'd0;

    // Timeout flush of 3 words with a next address ready.
    timeout_i = 32'd2500;
    pulse_wstb(32'h3000_0000);
    pulse_start();
    pulse_wstb(32'h3000_1000);
    push_burst(32'h3000_0000, 9'd3);
    push_irq(8'h04, 16'd3);
    fifo_count_i = 11'd3;
    cyc = 0;
    while (!dma_req_o && cyc < 3000) begin
      tick(1);
      cyc++;
    end
    check("tmo_latency", 32'(cyc), 32'd2500);
    tick(2);
    dma_ack_i    = 1'b1;
    tick(1);
    dma_ack_i    = 1'b0;
    timeout_i    = 32'd0;
    fifo_count_i = 11'd0;
    block_size_i = 32'd128;
    tick(3);

    // Block fills with no next address: starve, then a write resumes.
    push_burst(32'h3000_1000, 9'd16);
    push_burst(32'h3000_1040, 9'd16);
    push_irq(8'h09, 16'd32);
    fifo_count_i = 11'd64;
    do_burst();
    do_burst();
    tick(3);
    for (int i = 0; i < 10; i++) begin
      if (dma_req_o) break;
      tick(1);
    end
    check("starved_no_req", 32'(dma_req_o), 32'd0);
`ifdef PCAP_DMA_STATS_EN
    check("stats_blocks", blocks_o, 32'd4);
    check("stats_starved_nz", 32'(starved_o != 32'd0), 32'd1);
`endif
    push_burst(32'h2000_0000, 9'd16);
    pulse_wstb(32'h2000_0000);
    wait_req();

    // Abort during WAIT_ACK.
    push_irq(8'h10, 16'd0);
    tick(1);
    dma_reset_i = 1'b1;
    tick(1);
    dma_reset_i = 1'b0;
    check("abort_req", 32'(dma_req_o), 32'd0);
    check("abort_addr", dma_addr_o, 32'd0);
    check("abort_len", 32'(dma_len_o), 32'd0);
    check("abort_irq", 32'(irq_o), 32'd1);
    tick(1);
    check("abort_irq_single", 32'(irq_o), 32'd0);
    check("abort_flags_hold", 32'(irq_flags_o), 32'h10);
`ifdef PCAP_DMA_STATS_EN
    check("stats_blocks_abort", blocks_o, 32'd0);
`endif
    pulse_start();
    tick(10);
    check("start_no_pending", 32'(dma_req_o), 32'd0);

    // reset_i together with dma_ack_i.
    pulse_wstb(32'h4000_0000);
    pulse_start();
    push_burst(32'h4000_0000, 9'd16);
    wait_req();
    reset_i   = 1'b1;
    dma_ack_i = 1'b1;
    tick(1);
    reset_i   = 1'b0;
    dma_ack_i = 1'b0;
    check("rst2_req", 32'(dma_req_o), 32'd0);
    check("rst2_addr", dma_addr_o, 32'd0);
    check("rst2_len", 32'(dma_len_o), 32'd0);
    check("rst2_irq", 32'(irq_o), 32'd0);
    check("rst2_flags", 32'(irq_flags_o), 32'd0);
    check("rst2_words", 32'(irq_words_o), 32'd0);
`ifdef PCAP_DMA_STATS_EN
    check("rst2_blocks", blocks_o, 32'd0);
`endif
    tick(5);
    check("rst2_req_idle", 32'(dma_req_o), 32'd0);

    check("bursts_left", 32'(exp_burst_q.size()), 32'd0);
    check("irqs_left", 32'(exp_irq_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pcap_dma_ctrl.md
Name: pcap_dma_ctrl

Overview:
- Sequences DMA transfer of position-capture data from the capture data FIFO into host memory blocks.
- Holds a current/next host block address pair and issues fixed-length bursts or partial flush bursts.
- Tracks bytes written per block and raises IRQs on block full, capture complete, timeout or address starvation.
- Sits between the PCAP core/data FIFO and the HP AXI write master; the driver register block supplies its configuration.

Parameters:
- BURST_LEN, 16, words per full burst (power of 2, 1..256).
- CNT_W, 11, width of the FIFO word-count input.

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  synchronous active-high reset
- dma_reset_i  in  1  pulse: abort and return to IDLE, clear address pair
- dma_start_i  in  1  pulse: promote pending address to current and begin
- dma_addr_i  in  32  host block base address (byte, 32-byte aligned)
- dma_addr_wstb_i  in  1  pulse: load dma_addr_i into pending slot
- block_size_i  in  32  block size in bytes, multiple of 4*BURST_LEN
- timeout_i  in  32  flush timeout in clk_i cycles; 0 disables
- pcap_done_i  in  1  pulse: capture finished, flush and close block
- fifo_count_i  in  CNT_W  words available in data FIFO
- dma_req_o  out  1  burst request, held until dma_ack_i
- dma_addr_o  out  32  burst start byte address
- dma_len_o  out  9  burst length in words (1..BURST_LEN)
- dma_ack_i  in  1  pulse: burst fully written
- irq_o  out  1  single-cycle interrupt pulse
- irq_flags_o  out  8  b0 block full, b1 capture done, b2 timeout, b3 addr starved, b4 abort
- irq_words_o  out  16  words written to the block being reported

Behaviour:
- Reset or dma_reset_i, which win over every other input in the same cycle: all outputs 0, state IDLE, pending/current valid flags cleared, counters 0.
  - dma_reset_i while in WAIT_ACK: drop dma_req_o next cycle and pulse irq_o with flag b4.
  - No IRQ on reset_i.
- Address slot: dma_addr_wstb_i loads pending and sets pending_valid. A write while pending is already valid overwrites it.
- IDLE: on dma_start_i with pending_valid: current <= pending, pending_valid <= 0, offset <= 0, go to RUN. dma_start_i without pending_valid is ignored.
- RUN:
  - fifo_count_i >= BURST_LEN: dma_addr_o = current + offset, dma_len_o = BURST_LEN, dma_req_o = 1 on the next cycle; go to WAIT_ACK.
  - Flush condition (pcap_done_i latched, or timeout expired) with 0 < fifo_count_i < BURST_LEN: issue a partial burst with dma_len_o = fifo_count_i.
  - Flush with fifo_count_i = 0: go straight to CLOSE.
- WAIT_ACK: dma_req_o, dma_addr_o and dma_len_o stay stable until dma_ack_i. On dma_ack_i:
  - dma_req_o <= 0, offset += 4*len.
  - offset == block_size_i: CLOSE (b0).
  - Else, if a flush is pending and the FIFO is drained: CLOSE.
  - Else: RUN.
- CLOSE:
  - irq_o = 1 for one cycle.
  - irq_words_o = offset/4, saturating at 16'hFFFF.
  - irq_flags_o holds the accumulated reason bits.
  - If done was latched: b1 set, go to IDLE.
  - Else, if pending_valid: switch to the next address (current <= pending, offset 0), go to RUN.
  - Else: b3 set, go to STARVED.
- STARVED: no requests. dma_addr_wstb_i promotes the address to current immediately and moves to RUN; this raises no IRQ.
- Timeout:
  - Counter increments in RUN while offset > 0 or fifo_count_i > 0; clears on each irq_o.
  - Expires when count == timeout_i - 1. Sets b2 and forces a flush even when the block is not full.
- pcap_done_i may arrive in any state. It is latched and serviced on the next RUN entry; in IDLE it is ignored.
- Simultaneous full block and done: one IRQ with b0 | b1.
- irq_flags_o and irq_words_o hold their value until the next irq_o.

Optional Feature:
- PCAP_DMA_STATS_EN defined: adds output ports blocks_o[31:0] (blocks closed) and starved_o[31:0] (cycles spent in STARVED).
  - Both wrap at 2^32.
  - Both clear on reset_i or dma_reset_i.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Addr 0x1000_0000 wstb, start, addr 0x1000_0400 wstb; block_size 1024, fifo_count held 64 -> 16 bursts of 16 words at 0x1000_0000 + 64*i. IRQ b0 with irq_words_o = 256, then bursts continue at 0x1000_0400.
- After 2 full bursts, fifo_count 5, pcap_done_i pulse -> burst len 5 at offset 128. IRQ flags b1, irq_words_o = 37; state IDLE.
- timeout_i 2500, fifo_count held at 3 -> partial burst len 3 issued 2500 cycles after first data. IRQ b2, irq_words_o = 3.
- Block fills with no next address -> IRQ b3, no dma_req_o. Then wstb 0x2000_0000 -> next burst at 0x2000_0000 with no extra IRQ.
- dma_reset_i asserted during WAIT_ACK -> dma_req_o low the next cycle, IRQ b4, state IDLE. dma_start_i without a new wstb is ignored.
- reset_i asserted together with dma_ack_i -> all outputs 0, no IRQ. With PCAP_DMA_STATS_EN, blocks_o = 0.
